// File: rtl/sram_wb_arbiter.sv
// sram_wb_arbiter
// Two-master arbiter in front of a single SRAM controller. One transaction is
// in flight at a time: the winner's request is latched, presented to the
// controller for exactly one cycle, then the arbiter follows the controller's
// s_nak busy pulse (rise, then fall) before returning data and an ack.
// A counter aborts the transaction with err if the controller never responds.
//
// Handshake: a master raises mN_stb with addr/we/din stable and keeps it high
// until it sees mN_ack (one cycle, err alongside on a timeout). The arbiter
// raises s_stb for a single cycle per access; the controller answers by raising
// s_nak the next cycle and dropping it when read data on s_dout is valid.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   m0_*/m1_*  stb,addr,we,din   master requests (we all-zero = read)
//   m0_*/m1_*  dout,ack,err      master responses, registered
//   s_stb,s_addr,s_we,s_din      registered request to the SRAM controller
//   s_dout,s_nak                 controller read data and busy flag
//   fsm_state                    current FSM state, for observation
//
// Parameters
//   TIMEOUT    cycles allowed in the wait states before abort
//   FIXED_PRI  0 = round-robin on contention, 1 = m0 always wins
module sram_wb_arbiter #(
  parameter int TIMEOUT   = 15,
  parameter bit FIXED_PRI = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_stb,
  input  logic [31:0] m0_addr,
  input  logic [5:0]  m0_we,
  input  logic [47:0] m0_din,
  output logic [47:0] m0_dout,
  output logic        m0_ack,
  output logic        m0_err,
  input  logic        m1_stb,
  input  logic [31:0] m1_addr,
  input  logic [5:0]  m1_we,
  input  logic [47:0] m1_din,
  output logic [47:0] m1_dout,
  output logic        m1_ack,
  output logic        m1_err,
  output logic        s_stb,
  output logic [31:0] s_addr,
  output logic [5:0]  s_we,
  output logic [47:0] s_din,
  input  logic [47:0] s_dout,
  input  logic        s_nak,
  output logic [2:0]  fsm_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_WAIT_HI = 3'd2,
    S_WAIT_LO = 3'd3,
    S_ACK     = 3'd4
  } state_t;

  localparam logic [3:0] TMO = 4'(TIMEOUT);

  state_t     state;
  state_t     state_next;
  logic       grant;        // 0 = m0, 1 = m1 owns the current transaction
  logic       grant_next;
  logic       last_grant;   // master served by the previous completed access
  logic [3:0] tmo_cnt;
  logic       timeout_hit;
  logic       done_hit;

  assign fsm_state = state;

  always_comb begin
    state_next  = state;
    grant_next  = grant;
    timeout_hit = 1'b0;
    done_hit    = 1'b0;
    case (state)
      S_IDLE: begin
        if (m0_stb || m1_stb) begin
          state_next = S_ISSUE;
          if (m0_stb && m1_stb)
            grant_next = FIXED_PRI ? 1'b0 : ~last_grant;
          else
            grant_next = m1_stb;
        end
      end
      S_ISSUE: state_next = S_WAIT_HI;
      S_WAIT_HI: begin
        if (tmo_cnt == TMO) begin
          timeout_hit = 1'b1;
          state_next  = S_ACK;
        end else if (s_nak) begin
          state_next = S_WAIT_LO;
        end
      end
      S_WAIT_LO: begin
        // An expired counter wins over a late completion in the same cycle.
        if (tmo_cnt == TMO) begin
          timeout_hit = 1'b1;
          state_next  = S_ACK;
        end else if (!s_nak) begin
          done_hit   = 1'b1;
          state_next = S_ACK;
        end
      end
      S_ACK:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      tmo_cnt    <= 4'd0;
      s_stb      <= 1'b0;
      s_addr     <= 32'd0;
      s_we       <= 6'd0;
      s_din      <= 48'd0;
      m0_ack     <= 1'b0;
      m0_err     <= 1'b0;
      m0_dout    <= 48'd0;
      m1_ack     <= 1'b0;
      m1_err     <= 1'b0;
      m1_dout    <= 48'd0;
    end else begin
      state <= state_next;
      grant <= grant_next;

      // Outputs are registered from the next state so each one lines up
      // with the state it belongs to.
      s_stb <= (state_next == S_ISSUE);

      // The controller-side address/we/din registers double as the request
      // latch and hold until the next grant.
      if (state == S_IDLE && state_next == S_ISSUE) begin
        s_addr <= grant_next ? m1_addr : m0_addr;
        s_we   <= grant_next ? m1_we   : m0_we;
        s_din  <= grant_next ? m1_din  : m0_din;
      end

      if (state == S_ISSUE)
        tmo_cnt <= 4'd0;
      else if (state == S_WAIT_HI || state == S_WAIT_LO)
        tmo_cnt <= tmo_cnt + 4'd1;

      if (done_hit || timeout_hit) begin
        if (grant) begin
          m1_ack  <= 1'b1;
          m1_err  <= timeout_hit;
          m1_dout <= timeout_hit ? 48'd0 : s_dout;
        end else begin
          m0_ack  <= 1'b1;
          m0_err  <= timeout_hit;
          m0_dout <= timeout_hit ? 48'd0 : s_dout;
        end
      end

      if (state == S_ACK) begin
        m0_ack     <= 1'b0;
        m0_err     <= 1'b0;
        m0_dout    <= 48'd0;
        m1_ack     <= 1'b0;
        m1_err     <= 1'b0;
        m1_dout    <= 48'd0;
        last_grant <= grant;
      end
    end
  end

endmodule

// File: tb/tb_sram_wb_arbiter.sv
// Bench for sram_wb_arbiter: a round-robin instance and a fixed-priority
// instance share the master stimulus; each has its own controller model.
module tb_sram_wb_arbiter;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WAIT_LO = 3'd3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- stimulus signals ----------------
  logic        m0_stb, m1_stb;
  logic [31:0] m0_addr, m1_addr;
  logic [5:0]  m0_we, m1_we;
  logic [47:0] m0_din, m1_din;
  logic [47:0] ctrl_data;
  logic        nak_stuck;

  // round-robin instance
  logic [47:0] rr_m0_dout, rr_m1_dout, rr_s_din;
  logic        rr_m0_ack, rr_m1_ack, rr_m0_err, rr_m1_err, rr_s_stb, rr_s_nak;
  logic [31:0] rr_s_addr;
  logic [5:0]  rr_s_we;
  logic [2:0]  rr_state;
  logic [1:0]  rr_nak_cnt;

  // fixed-priority instance
  logic [47:0] fp_m0_dout, fp_m1_dout, fp_s_din;
  logic        fp_m0_ack, fp_m1_ack, fp_m0_err, fp_m1_err, fp_s_stb, fp_s_nak;
  logic [31:0] fp_s_addr;
  logic [5:0]  fp_s_we;
  logic [2:0]  fp_state;
  logic [1:0]  fp_nak_cnt;

  sram_wb_arbiter #(.TIMEOUT(15), .FIXED_PRI(1'b0)) dut_rr (
    .clk(clk), .rst(rst),
    .m0_stb(m0_stb), .m0_addr(m0_addr), .m0_we(m0_we), .m0_din(m0_din),
    .m0_dout(rr_m0_dout), .m0_ack(rr_m0_ack), .m0_err(rr_m0_err),
    .m1_stb(m1_stb), .m1_addr(m1_addr), .m1_we(m1_we), .m1_din(m1_din),
    .m1_dout(rr_m1_dout), .m1_ack(rr_m1_ack), .m1_err(rr_m1_err),
    .s_stb(rr_s_stb), .s_addr(rr_s_addr), .s_we(rr_s_we), .s_din(rr_s_din),
    .s_dout(ctrl_data), .s_nak(rr_s_nak), .fsm_state(rr_state)
  );

  sram_wb_arbiter #(.TIMEOUT(15), .FIXED_PRI(1'b1)) dut_fp (
    .clk(clk), .rst(rst),
    .m0_stb(m0_stb), .m0_addr(m0_addr), .m0_we(m0_we), .m0_din(m0_din),
    .m0_dout(fp_m0_dout), .m0_ack(fp_m0_ack), .m0_err(fp_m0_err),
    .m1_stb(m1_stb), .m1_addr(m1_addr), .m1_we(m1_we), .m1_din(m1_din),
    .m1_dout(fp_m1_dout), .m1_ack(fp_m1_ack), .m1_err(fp_m1_err),
    .s_stb(fp_s_stb), .s_addr(fp_s_addr), .s_we(fp_s_we), .s_din(fp_s_din),
    .s_dout(ctrl_data), .s_nak(fp_s_nak), .fsm_state(fp_state)
  );

  // Controller model: busy for two cycles starting the cycle after s_stb.
  // With nak_stuck set it never goes busy, forcing the timeout path.
  always @(posedge clk) begin
    if (rst) rr_nak_cnt <= 2'd0;
    else if (rr_s_stb && !nak_stuck) rr_nak_cnt <= 2'd2;
    else if (rr_nak_cnt != 2'd0) rr_nak_cnt <= rr_nak_cnt - 2'd1;
  end
  always @(posedge clk) begin
    if (rst) fp_nak_cnt <= 2'd0;
    else if (fp_s_stb && !nak_stuck) fp_nak_cnt <= 2'd2;
    else if (fp_nak_cnt != 2'd0) fp_nak_cnt <= fp_nak_cnt - 2'd1;
  end
  assign rr_s_nak = (rr_nak_cnt != 2'd0);
  assign fp_s_nak = (fp_nak_cnt != 2'd0);

  // ---------------- scoreboard ----------------
  // ack entry:   {cycle[15:0], master, err, dout[47:0]}
  // issue entry: {cycle[15:0], addr[31:0], we[5:0], din[47:0]}
  logic [65:0]  exp_rr_q[$];
  logic [65:0]  exp_fp_q[$];
  logic [101:0] exp_iss_q[$];
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push_ack(input bit to_fp, input int unsigned c, input bit m,
                          input bit err, input logic [47:0] d);
    if (to_fp) exp_fp_q.push_back({16'(c), m, err, d});
    else       exp_rr_q.push_back({16'(c), m, err, d});
  endtask

  task automatic push_both(input int unsigned c, input bit m, input bit err,
                           input logic [47:0] d);
    push_ack(1'b0, c, m, err, d);
    push_ack(1'b1, c, m, err, d);
  endtask

  task automatic push_iss(input int unsigned c, input logic [31:0] a,
                          input logic [5:0] w, input logic [47:0] d);
    exp_iss_q.push_back({16'(c), a, w, d});
  endtask

  task automatic cmp_ack(input string name, input logic [65:0] e,
                         input logic a0, input logic a1, input logic e0, input logic e1,
                         input logic [47:0] d0, input logic [47:0] d1);
    logic [115:0] act;
    logic [115:0] req;
    logic         m;
    m   = e[49];
    act = {16'(cyc), a0, a1, e0, e1, d0, d1};
    req = {e[65:50], ~m, m, ~m & e[48], m & e[48],
           m ? 48'd0 : e[47:0], m ? e[47:0] : 48'd0};
    check(name, 128'(act), 128'(req));
  endtask

  // Monitor: pops an expected response whenever an instance acks, checks
  // the idle response outputs otherwise, and tracks every s_stb.
  initial begin
    logic [65:0]  e;
    logic [101:0] ie;
    logic         rr_prev = 1'b0;
    logic         fp_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (rr_m0_ack || rr_m1_ack) begin
          if (exp_rr_q.size() == 0) check("rr_unexpected_ack", 128'({rr_m0_ack, rr_m1_ack}), 128'd0);
          else begin
            e = exp_rr_q.pop_front();
            cmp_ack("rr_ack", e, rr_m0_ack, rr_m1_ack, rr_m0_err, rr_m1_err, rr_m0_dout, rr_m1_dout);
          end
        end else begin
          check("rr_idle_resp", 128'({rr_m0_err, rr_m1_err, rr_m0_dout, rr_m1_dout}), 128'd0);
        end
        if (fp_m0_ack || fp_m1_ack) begin
          if (exp_fp_q.size() == 0) check("fp_unexpected_ack", 128'({fp_m0_ack, fp_m1_ack}), 128'd0);
          else begin
            e = exp_fp_q.pop_front();
            cmp_ack("fp_ack", e, fp_m0_ack, fp_m1_ack, fp_m0_err, fp_m1_err, fp_m0_dout, fp_m1_dout);
          end
        end else begin
          check("fp_idle_resp", 128'({fp_m0_err, fp_m1_err, fp_m0_dout, fp_m1_dout}), 128'd0);
        end
        if (rr_s_stb) begin
          check("rr_stb_back_to_back", 128'(rr_prev), 128'd0);
          if (exp_iss_q.size() == 0) check("rr_unexpected_stb", 128'(rr_s_stb), 128'd0);
          else begin
            ie = exp_iss_q.pop_front();
            check("rr_issue", 128'({16'(cyc), rr_s_addr, rr_s_we, rr_s_din}), 128'(ie));
          end
        end
        if (fp_s_stb) check("fp_stb_back_to_back", 128'(fp_prev), 128'd0);
      end
      rr_prev = rr_s_stb;
      fp_prev = fp_s_stb;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_until(input int unsigned n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_m(input bit m, input logic [31:0] a, input logic [5:0] w,
                         input logic [47:0] d);
    if (m) begin
      m1_addr = a; m1_we = w; m1_din = d; m1_stb = 1'b1;
    end else begin
      m0_addr = a; m0_we = w; m0_din = d; m0_stb = 1'b1;
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_rr_outputs"},
          128'({rr_s_stb, rr_s_addr, rr_s_we, rr_s_din, rr_m0_ack, rr_m1_ack,
                rr_m0_err, rr_m1_err, rr_state}), 128'd0);
    check({tag, "_rr_dout"}, 128'({rr_m0_dout, rr_m1_dout}), 128'd0);
    check({tag, "_fp_outputs"},
          128'({fp_s_stb, fp_s_addr, fp_s_we, fp_s_din, fp_m0_ack, fp_m1_ack,
                fp_m0_err, fp_m1_err, fp_state}), 128'd0);
    check({tag, "_fp_dout"}, 128'({fp_m0_dout, fp_m1_dout}), 128'd0);
  endtask

  // Watchdog: the directed sequence is only a couple hundred cycles long.
  initial begin
    #50000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int unsigned t0;
    int unsigned t1;
    rst = 1'b1;
    m0_stb = 1'b0; m0_addr = '0; m0_we = '0; m0_din = '0;
    m1_stb = 1'b0; m1_addr = '0; m1_we = '0; m1_din = '0;
    ctrl_data = '0;
    nak_stuck = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // m0 read at 0x10: s_stb in cycle 1, ack with controller data in cycle 5
    t0 = cyc;
    ctrl_data = 48'h1234_5678_9ABC;
    drive_m(1'b0, 32'h0000_0010, 6'd0, 48'd0);
    push_iss(t0 + 1, 32'h0000_0010, 6'd0, 48'd0);
    push_both(t0 + 5, 1'b0, 1'b0, 48'h1234_5678_9ABC);
    wait_until(t0 + 5);
    m0_stb = 1'b0;
    wait_until(t0 + 6);

    // m1 write at 0x08, we=000011: dout carries whatever s_dout held
    t0 = cyc;
    ctrl_data = 48'h5555_0000_1111;
    drive_m(1'b1, 32'h0000_0008, 6'b000011, 48'h0000_0000_AAAA);
    push_iss(t0 + 1, 32'h0000_0008, 6'b000011, 48'h0000_0000_AAAA);
    push_both(t0 + 5, 1'b1, 1'b0, 48'h5555_0000_1111);
    wait_until(t0 + 5);
    m1_stb = 1'b0;
    wait_until(t0 + 6);

    // Continuous contention: 6-cycle turns; RR alternates, FP keeps m0
    t0 = cyc;
    ctrl_data = 48'h0000_CAFE_0001;
    drive_m(1'b0, 32'h0000_0100, 6'd0, 48'd0);
    drive_m(1'b1, 32'h0000_0200, 6'h3F, 48'h0000_0000_BEEF);
    push_iss(t0 + 1,  32'h0000_0100, 6'd0,  48'd0);
    push_iss(t0 + 7,  32'h0000_0200, 6'h3F, 48'h0000_0000_BEEF);
    push_iss(t0 + 13, 32'h0000_0100, 6'd0,  48'd0);
    push_iss(t0 + 19, 32'h0000_0200, 6'h3F, 48'h0000_0000_BEEF);
    push_ack(1'b0, t0 + 5,  1'b0, 1'b0, 48'h0000_CAFE_0001);
    push_ack(1'b0, t0 + 11, 1'b1, 1'b0, 48'h0000_CAFE_0001);
    push_ack(1'b0, t0 + 17, 1'b0, 1'b0, 48'h0000_CAFE_0001);
    push_ack(1'b0, t0 + 23, 1'b1, 1'b0, 48'h0000_CAFE_0001);
    for (int k = 0; k < 4; k++)
      push_ack(1'b1, t0 + 5 + 6 * k, 1'b0, 1'b0, 48'h0000_CAFE_0001);
    wait_until(t0 + 23);
    m0_stb = 1'b0;
    m1_stb = 1'b0;
    wait_until(t0 + 24);

    // Timeout: counter 0 in cycle 2, 15 in cycle 17, err ack in cycle 18
    t0 = cyc;
    nak_stuck = 1'b1;
    ctrl_data = 48'hFFFF_FFFF_FFFF;
    drive_m(1'b0, 32'h0000_0040, 6'd0, 48'd0);
    push_iss(t0 + 1, 32'h0000_0040, 6'd0, 48'd0);
    push_both(t0 + 18, 1'b0, 1'b1, 48'd0);
    wait_until(t0 + 18);
    m0_stb = 1'b0;
    wait_until(t0 + 19);
    check("rr_timeout_idle", 128'(rr_state), 128'(ST_IDLE));
    check("fp_timeout_idle", 128'(fp_state), 128'(ST_IDLE));
    nak_stuck = 1'b0;
    wait_until(t0 + 20);

    // Reset in S_WAIT_LO: no ack, outputs cleared, m1 served right after
    t0 = cyc;
    ctrl_data = 48'h0123_4567_89AB;
    drive_m(1'b0, 32'h0000_0080, 6'd0, 48'd0);
    push_iss(t0 + 1, 32'h0000_0080, 6'd0, 48'd0);
    wait_until(t0 + 3);
    check("rr_in_wait_lo", 128'(rr_state), 128'(ST_WAIT_LO));
    rst = 1'b1;
    m0_stb = 1'b0;
    wait_until(t0 + 4);
    rst = 1'b0;
    check_zero("midreset");
    t1 = cyc;
    drive_m(1'b1, 32'h0000_00C0, 6'd0, 48'd0);
    push_iss(t1 + 1, 32'h0000_00C0, 6'd0, 48'd0);
    push_both(t1 + 5, 1'b1, 1'b0, 48'h0123_4567_89AB);
    wait_until(t1 + 5);
    m1_stb = 1'b0;
    wait_until(t1 + 8);

    check("rr_ack_queue_empty", 128'(exp_rr_q.size()), 128'd0);
    check("fp_ack_queue_empty", 128'(exp_fp_q.size()), 128'd0);
    check("rr_issue_queue_empty", 128'(exp_iss_q.size()), 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_wb_arbiter.md
SRAM_WB_ARBITER -- requirements
Module: sram_wb_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 15: maximum cycles spent in S_WAIT_HI or S_WAIT_LO before the transaction is aborted.
REQ-002 Parameter FIXED_PRI, default 0: 0 selects round-robin arbitration; 1 gives m0 fixed priority over m1.
REQ-003 clk  input  1  clock; all logic on posedge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 m0_stb / m1_stb  input  1  master request; held high until that master's ack.
REQ-006 m0_addr / m1_addr  input  32  byte address; bits [21:2] select the 48-bit word.
REQ-007 m0_we / m1_we  input  6  byte write enables; all zero means a read.
REQ-008 m0_din / m1_din  input  48  write data.
REQ-009 m0_dout / m1_dout  output  48  read data; valid in the ack cycle only.
REQ-010 m0_ack / m1_ack  output  1  one-cycle completion pulse.
REQ-011 m0_err / m1_err  output  1  one-cycle timeout pulse; coincides with the ack.
REQ-012 s_stb  output  1  request to the SRAM controller.
REQ-013 s_addr  output  32  address to the SRAM controller.
REQ-014 s_we  output  6  byte write enables to the SRAM controller.
REQ-015 s_din  output  48  write data to the SRAM controller.
REQ-016 s_dout  input  48  read data from the SRAM controller.
REQ-017 s_nak  input  1  controller busy; goes high the cycle after the accepted s_stb, stays high 2 cycles, then falls.

Function
REQ-018 FSM states: S_IDLE, S_ISSUE, S_WAIT_HI, S_WAIT_LO, S_ACK; all outputs are registered.
REQ-019 S_IDLE: if any m*_stb is high, latch the grant and the winner's addr/we/din, then go to S_ISSUE; otherwise stay in S_IDLE.
REQ-020 Arbitration when both masters request:
- FIXED_PRI=1: m0 wins.
- FIXED_PRI=0: the master not granted last wins.
- last-grant register resets to m1, so m0 wins the first contention.
REQ-021 A single requester always wins, regardless of FIXED_PRI.
REQ-022 S_ISSUE lasts exactly 1 cycle: s_stb=1 with the latched addr/we/din; next state S_WAIT_HI.
REQ-023 s_stb SHALL be 0 in every state other than S_ISSUE, so the controller never chains back-to-back accesses.
REQ-024 s_addr, s_we and s_din SHALL hold the latched values from S_ISSUE through S_ACK.
REQ-025 S_WAIT_HI: on s_nak=1 go to S_WAIT_LO.
REQ-026 S_WAIT_LO: on s_nak=0, capture s_dout into the granted master's dout, then go to S_ACK.
REQ-027 S_ACK lasts exactly 1 cycle: granted ack=1 and dout valid; then S_IDLE, and the last-grant register updates to the granted master.
REQ-028 Timeout: a 4-bit counter clears on entry to S_WAIT_HI and increments each cycle in S_WAIT_HI/S_WAIT_LO. On reaching TIMEOUT: go to S_ACK with ack=1, err=1, dout=0.
REQ-029 Read latency, stb in S_IDLE to ack, with a conforming controller: 5 cycles.
- m_stb sampled at cycle 0, s_stb in cycle 1, s_nak high in cycles 2-3.
- s_dout captured at the end of cycle 4, ack in cycle 5.
REQ-030 Write latency and timing are identical to reads; dout is undefined for writes and is driven with the captured s_dout.
REQ-031 The non-granted master's ack, err and dout SHALL stay 0 throughout the transaction.
REQ-032 Request changes during S_ISSUE to S_ACK are ignored; a deasserted stb does not cancel an in-flight transaction.
REQ-033 A master still requesting in S_IDLE after its ack is treated as a new request.

Reset
REQ-034 While rst=1 (sampled at posedge):
- state returns to S_IDLE; timeout counter returns to 0; last grant returns to m1.
- s_stb, s_addr, s_we, s_din, m*_ack, m*_err and m*_dout all return to 0.
REQ-035 rst asserted mid-transaction abandons it without an ack; the first grant is possible in the cycle after rst falls.

Verification
REQ-036 m0 read at addr 0x0000_0010, controller model returns 0x1234_5678_9ABC → s_stb in cycle 1 with s_addr=0x10, s_we=0; m0_ack and m0_dout=0x1234_5678_9ABC in cycle 5.
REQ-037 m1 write at addr 0x0000_0008, we=6'b000011, din=0xAAAA → s_stb once with s_we=6'b000011, s_din=0xAAAA; m1_ack in cycle 5; m0_ack stays 0.
REQ-038 Both masters request continuously with FIXED_PRI=0 → grants run m0, m1, m0, m1, each separated by S_IDLE; s_stb is never high for two consecutive cycles.
REQ-039 Same stimulus with FIXED_PRI=1 → m0 granted every time; m1 is never acked while m0_stb stays high.
REQ-040 Controller model holds s_nak=0 forever, TIMEOUT=15 → m0_ack=1, m0_err=1, m0_dout=0 in the cycle after the counter reaches 15; FSM back to S_IDLE.
REQ-041 rst pulsed in S_WAIT_LO → no ack issued, all outputs 0 the next cycle; a subsequent m1 request completes normally in 5 cycles.
